// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and 8-bit duty ratio of an external PWM input.
// Define PWM_CAPTURE_FILTER_EN to add a FILTER_CYC-sample glitch filter after the synchronizer.
module pwm_capture #(
    parameter int               CNT_W       = 16,
    parameter logic [CNT_W-1:0] TIMEOUT_CYC = 16'd50000,
    parameter int               FILTER_CYC  = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             capture_enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic [7:0]       duty_ratio,
    output logic             meas_done,
    output logic             signal_lost,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = 1;

    if (FILTER_CYC < 1 || FILTER_CYC > 255 || TIMEOUT_CYC == CNT_MAX) begin : g_param_check
        $error("pwm_capture: FILTER_CYC must be 1..255 and TIMEOUT_CYC below counter max");
    end

    logic sync1_q, sync2_q, prev_q;
    logic level, rise, fall, edge_seen;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic       filt_q;
    logic [7:0] fcnt_q;

    // Level flips only after FILTER_CYC consecutive samples disagree with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else if (sync2_q == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == 8'(FILTER_CYC - 1)) begin
            filt_q <= sync2_q;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 8'd1;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) prev_q <= 1'b0;
        else          prev_q <= level;
    end

    assign rise      = level & ~prev_q;
    assign fall      = ~level & prev_q;
    assign edge_seen = rise | fall;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q, high_raw_q, age_q;
    logic             div_busy_q;
    logic [3:0]       div_iter_q;
    logic [CNT_W-1:0] div_rem_q, div_per_q, div_high_q;
    logic [7:0]       div_quo_q;

    logic [CNT_W-1:0] cnt_inc_d, age_inc_d, rem_next_d;
    logic [CNT_W:0]   rem_shift_d, rem_sub_d;
    logic             rem_ge_d, div_last, div_free, div_done, timeout;

    assign cnt_inc_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;
    assign age_inc_d   = (age_q == CNT_MAX) ? age_q : age_q + ONE;
    assign rem_shift_d = {div_rem_q, 1'b0};
    assign rem_sub_d   = rem_shift_d - {1'b0, div_per_q};
    assign rem_ge_d    = rem_shift_d >= {1'b0, div_per_q};
    assign rem_next_d  = rem_ge_d ? rem_sub_d[CNT_W-1:0] : rem_shift_d[CNT_W-1:0];

    // The final divider cycle frees the divider, so a rise on that edge may reload it.
    assign div_last = (div_iter_q == 4'd8);
    assign div_free = !div_busy_q || div_last;
    assign div_done = div_busy_q && div_last && capture_enable;
    assign timeout  = capture_enable && (state_q != IDLE) && !edge_seen &&
                      (age_q >= TIMEOUT_CYC) && !signal_lost;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            high_raw_q   <= '0;
            age_q        <= '0;
            div_busy_q   <= 1'b0;
            div_iter_q   <= '0;
            div_rem_q    <= '0;
            div_per_q    <= '0;
            div_high_q   <= '0;
            div_quo_q    <= '0;
            high_count   <= '0;
            period_count <= '0;
            duty_ratio   <= '0;
            meas_done    <= 1'b0;
            signal_lost  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            meas_done <= 1'b0;
            age_q     <= (state_q == IDLE || edge_seen) ? '0 : age_inc_d;

            if (div_done) begin
                div_busy_q   <= 1'b0;
                high_count   <= div_high_q;
                period_count <= div_per_q;
                duty_ratio   <= div_quo_q;
                meas_done    <= 1'b1;
                signal_lost  <= 1'b0;
            end else if (div_busy_q) begin
                div_rem_q  <= rem_next_d;
                div_quo_q  <= {div_quo_q[6:0], rem_ge_d};
                div_iter_q <= div_iter_q + 4'd1;
            end

            case (state_q)
                IDLE: if (capture_enable) state_q <= WAIT_RISE;
                WAIT_RISE: if (rise) begin
                    cnt_q   <= ONE;
                    state_q <= HIGH;
                end
                HIGH: begin
                    cnt_q <= cnt_inc_d;
                    if (fall) begin
                        high_raw_q <= cnt_q;
                        state_q    <= LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        if (div_free) begin
                            div_busy_q <= 1'b1;
                            div_iter_q <= '0;
                            div_rem_q  <= high_raw_q;
                            div_per_q  <= cnt_q;
                            div_high_q <= high_raw_q;
                            div_quo_q  <= '0;
                        end else begin
                            overrun <= 1'b1;
                        end
                        cnt_q   <= ONE;
                        state_q <= HIGH;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Timeout overrides a divide finishing on the same edge.
            if (timeout) begin
                signal_lost  <= 1'b1;
                duty_ratio   <= level ? 8'hFF : 8'h00;
                high_count   <= '0;
                period_count <= '0;
                meas_done    <= 1'b1;
                div_busy_q   <= 1'b0;
                state_q      <= WAIT_RISE;
            end

            if (!capture_enable) begin
                state_q    <= IDLE;
                div_busy_q <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: expected results are queued as PWM stimulus is driven
// and popped when meas_done pulses.
module tb_pwm_capture;

    localparam int W = 16;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT    = 15;
    localparam int NARROW = 3;
`else
    localparam int LAT    = 12;
    localparam int NARROW = 1;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          capture_enable = 1'b0;
    logic          pwm_in = 1'b0;
    logic [W-1:0]  high_count, period_count;
    logic [7:0]    duty_ratio;
    logic          meas_done, signal_lost, overrun;

    pwm_capture #(.CNT_W(W), .TIMEOUT_CYC(16'd300), .FILTER_CYC(3)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .capture_enable (capture_enable),
        .pwm_in         (pwm_in),
        .high_count     (high_count),
        .period_count   (period_count),
        .duty_ratio     (duty_ratio),
        .meas_done      (meas_done),
        .signal_lost    (signal_lost),
        .overrun        (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] hc;
        logic [W-1:0] pc;
        logic [7:0]   duty;
        logic         lost;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_rise_cyc = 0;
    bit   lat_chk = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void push_meas(input int hi, input int per);
        exp_t e;
        e.hc   = W'(hi);
        e.pc   = W'(per);
        e.duty = 8'((hi * 256) / per);
        e.lost = 1'b0;
        expq.push_back(e);
    endfunction

    function automatic void push_lost(input logic [7:0] duty);
        exp_t e;
        e.hc   = '0;
        e.pc   = '0;
        e.duty = duty;
        e.lost = 1'b1;
        expq.push_back(e);
    endfunction

    always @(negedge clock) begin
        if (reset_n && meas_done === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done at cyc %0d: got hc=%0d pc=%0d duty=%0d lost=%b, required no pulse",
                         cyc, high_count, period_count, duty_ratio, signal_lost);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if ({high_count, period_count, duty_ratio, signal_lost} !== {e.hc, e.pc, e.duty, e.lost}) begin
                    failures++;
                    $display("FAIL result at cyc %0d: got hc=%0d pc=%0d duty=%0d lost=%b, required hc=%0d pc=%0d duty=%0d lost=%b",
                             cyc, high_count, period_count, duty_ratio, signal_lost, e.hc, e.pc, e.duty, e.lost);
                end
            end
            if (lat_chk) begin
                checks++;
                if (cyc - last_rise_cyc != LAT) begin
                    failures++;
                    $display("FAIL latency: got %0d clocks from pin rise, required %0d", cyc - last_rise_cyc, LAT);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic hold(input logic v, input int n);
        @(posedge clock);
        #1;
        if (v && !pwm_in) last_rise_cyc = cyc;
        pwm_in = v;
        repeat (n - 1) @(posedge clock);
    endtask

    task automatic start_capture();
        @(posedge clock);
        #1;
        pwm_in = 1'b0;
        capture_enable = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    task automatic stop_capture(input string name);
        @(posedge clock);
        #1;
        capture_enable = 1'b0;
        pwm_in = 1'b0;
        repeat (5) @(posedge clock);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL %s_missing: %0d results still pending, required 0", name, expq.size());
            expq.delete();
        end
    endtask

    // n full periods after an aligning rise, then a closing rise; yields n results.
    task automatic run_std(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) push_meas(hi, hi + lo);
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
        push_meas(hi, hi + lo);
        hold(1'b1, 15);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({high_count, period_count, duty_ratio, meas_done, signal_lost, overrun} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got hc=%0d pc=%0d duty=%0d done=%b lost=%b ovr=%b, required all 0",
                     high_count, period_count, duty_ratio, meas_done, signal_lost, overrun);
        end
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clock);
    endtask

    task automatic test_basic();
        start_capture();
        lat_chk = 1'b1;
        run_std(40, 60, 4);
        lat_chk = 1'b0;
        checks++;
        if (overrun !== 1'b0 || signal_lost !== 1'b0) begin
            failures++;
            $display("FAIL basic_flags: got ovr=%b lost=%b, required 0 0", overrun, signal_lost);
        end
        stop_capture("basic");
    endtask

    task automatic test_extremes();
        start_capture();
        run_std(NARROW, 256 - NARROW, 2);
        stop_capture("narrow_high");
        start_capture();
        run_std(256 - NARROW, NARROW, 2);
        stop_capture("narrow_low");
    endtask

    task automatic test_timeout();
        start_capture();
        run_std(40, 60, 1);
        push_lost(8'hFF);
        hold(1'b1, 400);
        checks++;
        if (signal_lost !== 1'b1 || duty_ratio !== 8'hFF || high_count !== '0 || period_count !== '0) begin
            failures++;
            $display("FAIL timeout_state: got lost=%b duty=%0d hc=%0d pc=%0d, required 1 255 0 0",
                     signal_lost, duty_ratio, high_count, period_count);
        end
        hold(1'b0, 60);
        run_std(40, 60, 1);
        checks++;
        if (signal_lost !== 1'b0 || duty_ratio !== 8'd102) begin
            failures++;
            $display("FAIL timeout_recover: got lost=%b duty=%0d, required 0 102", signal_lost, duty_ratio);
        end
        stop_capture("timeout");
    endtask

    task automatic test_overrun();
        start_capture();
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_start: got %b, required 0", overrun);
        end
        // Rises alternate between loading the divider and landing while it is busy.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) push_meas(3, 6);
            hold(1'b1, 3);
            hold(1'b0, 3);
        end
        repeat (15) @(posedge clock);
        #1;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: got %b, required 1", overrun);
        end
        stop_capture("overrun");
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: got %b, required 0", overrun);
        end
    endtask

    task automatic test_disable();
        start_capture();
        hold(1'b1, 40);
        hold(1'b0, 60);
        push_meas(40, 100);
        hold(1'b1, 40);
        hold(1'b0, 60);
        hold(1'b1, 6);
        #1 capture_enable = 1'b0;
        hold(1'b1, 34);
        hold(1'b0, 30);
        checks++;
        if (high_count !== 16'd40 || period_count !== 16'd100 || duty_ratio !== 8'd102 ||
            signal_lost !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL disable_hold: got hc=%0d pc=%0d duty=%0d lost=%b ovr=%b, required 40 100 102 0 0",
                     high_count, period_count, duty_ratio, signal_lost, overrun);
        end
        start_capture();
        run_std(25, 75, 1);
        stop_capture("disable");
    endtask

    task automatic test_glitch();
        start_capture();
        for (int i = 0; i < 3; i++) begin
`ifdef PWM_CAPTURE_FILTER_EN
            if (i > 0) push_meas(40, 100);
`else
            if (i > 0) push_meas(19, 79);
`endif
            hold(1'b1, 20);
`ifndef PWM_CAPTURE_FILTER_EN
            push_meas(20, 21);
`endif
            hold(1'b0, 1);
            hold(1'b1, 19);
            hold(1'b0, 60);
        end
`ifdef PWM_CAPTURE_FILTER_EN
        push_meas(40, 100);
`else
        push_meas(19, 79);
`endif
        hold(1'b1, 15);
        stop_capture("glitch");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_timeout();
        test_overrun();
        test_disable();
        test_glitch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
